// File: rtl/cla_accum_pkg.sv
// Shared types and constants for the CLA result accumulator.
// Optional saturation is selected by CLA_ACCUM_SAT_EN (see acc_sat_add).
package cla_pkg;
  localparam int CLA_W       = 32;
  localparam int N_TERMS_DEF = 8;
  localparam int ACC_W_DEF   = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Upstream adder result as an unsigned 33-bit term.
  function automatic logic [CLA_W:0] mk_term(input logic cout, input logic [CLA_W-1:0] sum);
    return {cout, sum};
  endfunction
endpackage

// File: rtl/cla_accum_if.sv
// Term stream, batch result handshake and status for cla_accum.
interface cla_accum_if import cla_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF
);
  logic             start;
  logic             in_valid;
  logic [CLA_W-1:0] in_sum;
  logic             in_cout;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic [7:0]       term_cnt;
  logic             ovf;

  modport master (
    output start, in_valid, in_sum, in_cout, acc_ready,
    input  in_ready, acc_out, acc_valid, term_cnt, ovf
  );

  modport slave (
    input  start, in_valid, in_sum, in_cout, acc_ready,
    output in_ready, acc_out, acc_valid, term_cnt, ovf
  );
endinterface

// File: rtl/cla_accum_sat_add.sv
// Combinational ACC_W + 33-bit adder with carry-out flag.
// CLA_ACCUM_SAT_EN defined: sum clamps to all ones on carry-out; otherwise wraps.
module acc_sat_add import cla_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [CLA_W:0]   b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic [ACC_W:0] full;

  assign full = {1'b0, a} + {{(ACC_W-CLA_W){1'b0}}, b};
  assign ovf  = full[ACC_W];

`ifdef CLA_ACCUM_SAT_EN
  assign sum = ovf ? '1 : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/cla_accum.sv
// Sums N_TERMS registered CLA results per batch, holds the total until taken.
// Build option CLA_ACCUM_SAT_EN: saturate acc_out on overflow instead of wrapping.
module cla_accum import cla_pkg::*; #(
  parameter int N_TERMS = N_TERMS_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input logic         CLK,
  input logic         RESET,
  cla_accum_if.slave  bus
);
  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, add_sum;
  logic [7:0]       cnt;
  logic             ovf, add_ovf;
  logic             in_rdy, acc_vld, clr, accept, last;

  assign accept = in_rdy && bus.in_valid;
  assign last   = accept && (cnt == 8'(N_TERMS-1));

  acc_sat_add #(.ACC_W(ACC_W)) u_add (
    .a   (acc),
    .b   (mk_term(bus.in_cout, bus.in_sum)),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    in_rdy   = 1'b0;
    acc_vld  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = ACCUM;
          clr      = 1'b1;
        end
      end
      ACCUM: begin
        in_rdy = 1'b1;
        if (last) state_nx = HOLD;
      end
      HOLD: begin
        acc_vld = 1'b1;
        // start only counts once the consumer has taken the result
        if (bus.acc_ready) begin
          clr      = bus.start;
          state_nx = bus.start ? ACCUM : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      cnt <= cnt + 8'd1;
      ovf <= ovf | add_ovf;
`ifdef CLA_ACCUM_SAT_EN
      if (!ovf) acc <= add_sum;
`else
      acc <= add_sum;
`endif
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.acc_valid = acc_vld;
  assign bus.acc_out   = acc;
  assign bus.term_cnt  = cnt;
  assign bus.ovf       = ovf;
endmodule

// File: tb/tb_cla_accum.sv
// Self-checking bench for cla_accum: directed table, hand sequences, random batches.
module tb_cla_accum;
  import cla_pkg::*;

  localparam int NT = 4;
`ifdef CLA_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_accum_if #(.ACC_W(48)) ifa();
  cla_accum_if #(.ACC_W(34)) ifb();

  cla_accum #(.N_TERMS(NT), .ACC_W(48)) dut_a (.CLK(clk), .RESET(rst), .bus(ifa.slave));
  cla_accum #(.N_TERMS(NT), .ACC_W(34)) dut_b (.CLK(clk), .RESET(rst), .bus(ifb.slave));

  typedef struct packed {
    logic        rdy;
    logic        vld;
    logic        ovf;
    logic [7:0]  cnt;
    logic [63:0] acc;
  } obs_t;

  typedef struct {
    int                   sel;
    logic [NT-1:0][32:0]  t;
    int                   gap;
    logic [63:0]          exp_acc;
    logic                 exp_ovf;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv(input int sel, input logic st, input logic v, input logic [32:0] t, input logic ar);
    if (sel == 0) begin
      ifa.start = st; ifa.in_valid = v; ifa.in_cout = t[32]; ifa.in_sum = t[31:0]; ifa.acc_ready = ar;
    end else begin
      ifb.start = st; ifb.in_valid = v; ifb.in_cout = t[32]; ifb.in_sum = t[31:0]; ifb.acc_ready = ar;
    end
  endtask

  function automatic obs_t obs(input int sel);
    obs_t o;
    if (sel == 0) o = '{ifa.in_ready, ifa.acc_valid, ifa.ovf, ifa.term_cnt, 64'(ifa.acc_out)};
    else          o = '{ifb.in_ready, ifb.acc_valid, ifb.ovf, ifb.term_cnt, 64'(ifb.acc_out)};
    return o;
  endfunction

  // Feeds NT terms to a DUT already in ACCUM, checks result latency, optionally
  // stalls in HOLD, then releases the result.
  task automatic feed(input int sel, input logic [NT-1:0][32:0] t, input int gap, input int hold,
                      output logic [63:0] acc, output logic ov);
    obs_t o;
    for (int i = 0; i < NT; i++) begin
      drv(sel, 0, 1, t[i], 0);
      if (i == NT-1) begin
        o = obs(sel);
        chk("pre_valid", 64'(o.vld), 0);
      end
      tick();
      if (i < NT-1)
        for (int g = 0; g < gap; g++) begin
          drv(sel, 0, 0, 0, 0);
          o = obs(sel);
          chk("gap_cnt", 64'(o.cnt), 64'(i+1));
          tick();
        end
    end
    drv(sel, 0, 0, 0, 0);
    o = obs(sel);
    chk("latency", 64'(o.vld), 1);
    chk("hold_cnt", 64'(o.cnt), NT);
    acc = o.acc;
    ov  = o.ovf;
    for (int h = 0; h < hold; h++) begin
      tick();
      o = obs(sel);
      chk("hold_acc", o.acc, acc);
    end
    drv(sel, 0, 0, 0, 1);
    tick();
    drv(sel, 0, 0, 0, 0);
  endtask

  task automatic run_batch(input int sel, input logic [NT-1:0][32:0] t, input int gap, input int hold,
                           output logic [63:0] acc, output logic ov);
    drv(sel, 1, 0, 0, 0);
    tick();
    feed(sel, t, gap, hold, acc, ov);
  endtask

  // Reference: final total from plain arithmetic on the term list.
  function automatic logic [64:0] model(input int sel, input logic [NT-1:0][32:0] t);
    logic [63:0] tot, lim;
    logic        ov;
    tot = 0;
    for (int i = 0; i < NT; i++) tot += 64'(t[i]);
    lim = 64'd1 << (sel == 0 ? 48 : 34);
    ov  = (tot >= lim);
    if (ov && SAT) return {1'b1, lim - 64'd1};
    return {ov, tot % lim};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[7];
    obs_t        o;
    logic [63:0] a;
    logic        ov;
    logic [64:0] m;
    logic [NT-1:0][32:0] rt;

    vecs[0] = '{0, {33'd4, 33'd3, 33'd2, 33'd1}, 0, 64'd10, 1'b0};
    vecs[1] = '{0, {4{33'h1_FFFF_FFFF}}, 0, 64'h7_FFFF_FFFC, 1'b0};
    vecs[2] = '{0, {4{33'd5}}, 1, 64'd20, 1'b0};
    vecs[3] = '{1, {4{33'h1_FFFF_FFFF}}, 0, SAT ? 64'h3_FFFF_FFFF : 64'h3_FFFF_FFFC, 1'b1};
    vecs[4] = '{0, {33'h0_FFFF_FFFF, 33'd0, 33'd1, 33'h1_0000_0000}, 2, 64'h2_0000_0000, 1'b0};
    vecs[5] = '{1, {4{33'h1_0000_0000}}, 0, SAT ? 64'h3_FFFF_FFFF : 64'h0, 1'b1};
    vecs[6] = '{1, {4{33'd1}}, 1, 64'd4, 1'b0};

    rst = 1'b1;
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    tick(); tick();
    o = obs(0);
    chk("rst_rdy", 64'(o.rdy), 0);
    chk("rst_vld", 64'(o.vld), 0);
    chk("rst_acc", o.acc, 0);
    chk("rst_cnt", 64'(o.cnt), 0);
    chk("rst_ovf", 64'(o.ovf), 0);
    rst = 1'b0;

    // in_valid pulses while IDLE must be ignored
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 1, 33'd7, 0);
      tick();
      drv(0, 0, 0, 0, 0);
      o = obs(0);
      chk("idle_rdy", 64'(o.rdy), 0);
      chk("idle_cnt", 64'(o.cnt), 0);
      chk("idle_acc", o.acc, 0);
      tick();
    end

    foreach (vecs[i]) begin
      run_batch(vecs[i].sel, vecs[i].t, vecs[i].gap, 0, a, ov);
      chk($sformatf("vec%0d_acc", i), a, vecs[i].exp_acc);
      chk($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].exp_ovf));
    end

    // HOLD stall with ignored in_valid/start, then back-to-back start
    drv(0, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < NT; i++) begin
      drv(0, 0, 1, 33'(i+1), 0);
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      drv(0, c == 2, c % 2, 33'd9, 0);
      tick();
      o = obs(0);
      chk("stall_acc", o.acc, 10);
      chk("stall_cnt", 64'(o.cnt), NT);
      chk("stall_vld", 64'(o.vld), 1);
    end
    drv(0, 1, 0, 0, 1);
    tick();
    drv(0, 0, 0, 0, 0);
    o = obs(0);
    chk("b2b_acc", o.acc, 0);
    chk("b2b_cnt", 64'(o.cnt), 0);
    chk("b2b_rdy", 64'(o.rdy), 1);
    chk("b2b_vld", 64'(o.vld), 0);
    feed(0, {33'd40, 33'd30, 33'd20, 33'd10}, 0, 0, a, ov);
    chk("b2b_sum", a, 100);

    // start ignored in ACCUM, then reset mid-batch
    drv(0, 1, 0, 0, 0);
    tick();
    drv(0, 1, 1, 33'd100, 0);
    tick();
    drv(0, 1, 1, 33'd200, 0);
    tick();
    o = obs(0);
    chk("accum_start_cnt", 64'(o.cnt), 2);
    chk("accum_start_acc", o.acc, 300);
    drv(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    o = obs(0);
    chk("midrst_acc", o.acc, 0);
    chk("midrst_cnt", 64'(o.cnt), 0);
    chk("midrst_ovf", 64'(o.ovf), 0);
    chk("midrst_vld", 64'(o.vld), 0);
    chk("midrst_rdy", 64'(o.rdy), 0);
    run_batch(0, {4{33'd5}}, 0, 0, a, ov);
    chk("after_rst_acc", a, 20);

    // random batches on both widths
    for (int r = 0; r < 24; r++) begin
      int sel;
      sel = r % 2;
      for (int i = 0; i < NT; i++) rt[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
      m = model(sel, rt);
      run_batch(sel, rt, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), a, ov);
      chk($sformatf("rnd%0d_acc", r), a, m[63:0]);
      chk($sformatf("rnd%0d_ovf", r), 64'(ov), 64'(m[64]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cla_accum.md
CLA_ACCUM -- requirements
Module: cla_accum

Interface
REQ-001 SHALL have parameter N_TERMS, default 8: number of adder results summed per batch. Legal range is 1..255.
REQ-002 SHALL have parameter ACC_W, default 48: accumulator width. Minimum is 34.
REQ-003 CLK  input  1  rising-edge clock; one clock, everything synchronous to it.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin a new batch.
REQ-006 in_valid  input  1  in_sum/in_cout valid; driven by the registered 32-bit CLA stage upstream.
REQ-007 in_sum  input  32  adder sum.
REQ-008 in_cout  input  1  adder carry-out.
REQ-009 in_ready  output  1  accumulator accepts a term.
REQ-010 acc_out  output  ACC_W  batch total.
REQ-011 acc_valid  output  1  acc_out holds a complete batch.
REQ-012 acc_ready  input  1  consumer takes acc_out.
REQ-013 term_cnt  output  8  terms accepted in the current batch.
REQ-014 ovf  output  1  sticky overflow for the current batch.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-016 IDLE: in_ready=0 and acc_valid=0; start=1 moves to ACCUM and clears acc_out, term_cnt and ovf to 0.
REQ-017 ACCUM: in_ready=1.
- A term is accepted on in_valid&&in_ready.
- acc_out <= acc_out + zero-extended {in_cout,in_sum} (33-bit term).
- term_cnt increments by 1 per accepted term.
REQ-018 The term accepted with term_cnt==N_TERMS-1 SHALL move the FSM to HOLD.
- acc_valid=1 on the next cycle; total latency is one cycle after the final term.
- term_cnt shows N_TERMS in HOLD.
REQ-019 HOLD: in_ready=0; acc_out, ovf and term_cnt stay stable until acc_ready=1.
REQ-020 HOLD with acc_ready=1 and start=0 SHALL go to IDLE.
REQ-021 HOLD with acc_ready=1 and start=1 SHALL go directly to ACCUM with the clears of REQ-016 (back-to-back batches).
REQ-022 start SHALL be ignored in ACCUM, and in HOLD when acc_ready=0.
REQ-023 in_valid SHALL be ignored in IDLE and HOLD; nothing is accumulated or counted.
REQ-024 Gaps in in_valid during ACCUM SHALL NOT alter state, acc_out or term_cnt.
REQ-025 A carry out of bit ACC_W-1 during an addition SHALL set ovf; ovf stays set until the next batch clear.

Reset
REQ-026 RESET=1 on a clock edge SHALL force state=IDLE, acc_out=0, term_cnt=0, ovf=0, acc_valid=0 and in_ready=0.
REQ-027 RESET has priority over every other input.
REQ-028 A reset mid-batch SHALL discard the partial sum; the next batch is unaffected.

Configuration
REQ-029 SHALL support the macro CLA_ACCUM_SAT_EN.
- Defined: on overflow, acc_out saturates to all ones and holds there for the rest of the batch.
- Undefined: acc_out wraps modulo 2^ACC_W.
- ovf SHALL behave identically in both cases.

Structure
REQ-030 Shared package cla_pkg SHALL hold:
- the state enum (IDLE, ACCUM, HOLD);
- the constant CLA_W=32;
- the default constants for N_TERMS and ACC_W.
REQ-031 SHALL contain one sub-module, acc_sat_add: a combinational ACC_W adder returning the sum and an overflow flag, with saturation controlled by CLA_ACCUM_SAT_EN.

Verification (N_TERMS=4, ACC_W=48 unless stated)
REQ-032 Bench SHALL drive RESET, start, then terms 1,2,3,4 with cout=0.
- Required: acc_out=10, ovf=0.
- acc_valid rises the cycle after the 4th term is accepted.
REQ-033 Bench SHALL drive 4 terms with sum=0xFFFFFFFF, cout=1.
- Required: acc_out=0x7_FFFF_FFFC, ovf=0.
REQ-034 Bench SHALL drive in_valid every other cycle, plus 3 pulses while IDLE.
- Required: only ACCUM terms are counted; term_cnt=4 in HOLD; in_ready=0 in IDLE.
REQ-035 Bench SHALL hold acc_ready=0 for 5 cycles in HOLD, then assert acc_ready and start together.
- Required: acc_out is stable during the hold.
- Next cycle: ACCUM with acc_out=0 and term_cnt=0.
REQ-036 Bench SHALL assert RESET after 2 terms, then run a batch of 5,5,5,5.
- Required: all outputs are 0 and the FSM is IDLE after reset.
- Then acc_out=20.
REQ-037 Bench SHALL run ACC_W=34 with 4 terms of 0x1_FFFF_FFFF.
- Required: ovf=1.
- Without the macro: acc_out=0x3_FFFF_FFFC.
- With CLA_ACCUM_SAT_EN: acc_out=0x3_FFFF_FFFF.
